// File: rtl/register_file_mp.sv
// Multi-ported CPU register file with a pending-write scoreboard.
//
// Optional feature: define REG_FILE_WR_BYPASS_EN to forward same-cycle write
// data (and the matching pending clear) onto the read ports. The default build
// has no forwarding, so a write becomes visible on the cycle after the edge.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset, clears data and scoreboard
//   rd_sel       packed read selects, SEL_W bits per read port
//   rd_data      packed read data, DATA_WIDTH bits per read port
//   rd_pending   per read port, 1 = selected register has a reservation
//   wr_en        per write port enable (higher index = higher priority)
//   wr_sel       packed write targets, SEL_W bits per write port
//   wr_data      packed write data, DATA_WIDTH bits per write port
//   rsv_en       mark register rsv_sel pending at the edge
//   rsv_sel      register to reserve
//   pending_vec  full scoreboard, bit i = register i pending
module register_file_mp #(
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_RD_PORTS = 3,
  parameter int unsigned NUM_WR_PORTS = 2,
  parameter int unsigned ZERO_REG     = 1,
  localparam int unsigned SEL_W       = $clog2(NUM_REGS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_RD_PORTS*SEL_W-1:0]      rd_sel,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]            rd_pending,
  input  logic [NUM_WR_PORTS-1:0]            wr_en,
  input  logic [NUM_WR_PORTS*SEL_W-1:0]      wr_sel,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                               rsv_en,
  input  logic [SEL_W-1:0]                   rsv_sel,
  output logic [NUM_REGS-1:0]                pending_vec
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pending_q;
  logic [NUM_REGS-1:0]   pending_d;

  // Register 0 is hardwired to zero only when ZERO_REG is set.
  function automatic logic is_zero(input logic [SEL_W-1:0] sel);
    return (ZERO_REG != 0) && (sel == '0);
  endfunction

  // Ascending port order lets the highest-index enabled writer land last and
  // win a same-register conflict. The reservation is applied after all writes
  // so a new producer keeps the register pending even when it is written.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      if (wr_en[p] && !is_zero(wr_sel[p*SEL_W +: SEL_W])) begin
        regs_d[wr_sel[p*SEL_W +: SEL_W]]    = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        pending_d[wr_sel[p*SEL_W +: SEL_W]] = 1'b0;
      end
    end
    if (rsv_en && !is_zero(rsv_sel)) begin
      pending_d[rsv_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q    <= '{default: '0};
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  assign pending_vec = pending_q;

  for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
    logic [SEL_W-1:0]      sel;
    logic [DATA_WIDTH-1:0] data;
    logic                  pend;

    assign sel = rd_sel[i*SEL_W +: SEL_W];

    always_comb begin
      data = regs_q[sel];
      pend = pending_q[sel];
`ifdef REG_FILE_WR_BYPASS_EN
      // Forwarded write completes the producer, so pending drops unless a
      // new reservation for the same register is issued this cycle.
      if (!rst) begin
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          if (wr_en[p] && (wr_sel[p*SEL_W +: SEL_W] == sel)) begin
            data = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
            pend = rsv_en && (rsv_sel == sel);
          end
        end
      end
`endif
      if (is_zero(sel)) begin
        data = '0;
        pend = 1'b0;
      end
    end

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rd_pending[i]                       = pend;
  end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;
  localparam int unsigned NR  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned NRD = 3;
  localparam int unsigned NWR = 2;
  localparam int unsigned SW  = 4;
  localparam int unsigned ZR  = 1;
`ifdef REG_FILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NRD*SW-1:0] rd_sel;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]   rd_pending;
  logic [NWR-1:0]   wr_en;
  logic [NWR*SW-1:0] wr_sel;
  logic [NWR*DW-1:0] wr_data;
  logic             rsv_en;
  logic [SW-1:0]    rsv_sel;
  logic [NR-1:0]    pending_vec;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Architectural model state
  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];

  register_file_mp #(
    .NUM_REGS(NR), .DATA_WIDTH(DW), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR), .ZERO_REG(ZR)
  ) dut (
    .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_data), .rd_pending(rd_pending),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
    .pending_vec(pending_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // What a read of register sel must return given model state and current inputs.
  function automatic void model_read(input int unsigned sel, output logic [DW-1:0] d,
                                     output logic p);
    d = m_regs[sel];
    p = m_pend[sel];
    if (BYP && !rst) begin
      for (int q = 0; q < NWR; q++) begin
        if (wr_en[q] && (wr_sel[q*SW +: SW] == sel[SW-1:0])) begin
          d = wr_data[q*DW +: DW];
          p = rsv_en && (rsv_sel == sel[SW-1:0]);
        end
      end
    end
    if (ZR != 0 && sel == 0) begin
      d = '0;
      p = 1'b0;
    end
  endfunction

  // Model update at each edge: highest enabled writer per register wins.
  always @(posedge clk) begin : model_upd
    bit          done [NR];
    int unsigned s;
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        m_regs[r] = '0;
        m_pend[r] = 1'b0;
      end
    end else begin
      for (int r = 0; r < NR; r++) done[r] = 1'b0;
      for (int q = NWR - 1; q >= 0; q--) begin
        s = int'(wr_sel[q*SW +: SW]);
        if (wr_en[q] && !done[s] && !(ZR != 0 && s == 0)) begin
          done[s]   = 1'b1;
          m_regs[s] = wr_data[q*DW +: DW];
          m_pend[s] = 1'b0;
        end
      end
      if (rsv_en && !(ZR != 0 && rsv_sel == '0)) m_pend[rsv_sel] = 1'b1;
    end
  end

  // Compare process: every cycle, well away from the rising edge.
  always begin : compare
    logic [DW-1:0] d;
    logic          p;
    logic [NR-1:0] pv;
    @(negedge clk);
    #2;
    if (chk_en) begin
      for (int i = 0; i < NRD; i++) begin
        model_read(int'(rd_sel[i*SW +: SW]), d, p);
        chk($sformatf("model_rd_data[%0d]", i), 64'(rd_data[i*DW +: DW]), 64'(d));
        chk($sformatf("model_rd_pending[%0d]", i), 64'(rd_pending[i]), 64'(p));
      end
      for (int r = 0; r < NR; r++) pv[r] = m_pend[r];
      chk("model_pending_vec", 64'(pending_vec), 64'(pv));
    end
  end

  task automatic nxt();
    @(negedge clk);
    rst    = 1'b0;
    wr_en  = '0;
    rsv_en = 1'b0;
  endtask

  task automatic set_rd(input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                        input logic [SW-1:0] s2);
    rd_sel = {s2, s1, s0};
  endtask

  task automatic set_wr(input int p, input logic [SW-1:0] s, input logic [DW-1:0] d);
    wr_en[p]            = 1'b1;
    wr_sel[p*SW +: SW]  = s;
    wr_data[p*DW +: DW] = d;
  endtask

  initial begin
    rst = 1'b1; rd_sel = '0; wr_en = '0; wr_sel = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_sel = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;

    // Reset state over every select
    for (int s = 0; s < NR; s++) begin
      nxt();
      set_rd(SW'(s), SW'(s), SW'(s));
      #3;
      for (int i = 0; i < NRD; i++) chk("reset_rd_data", 64'(rd_data[i*DW +: DW]), 64'd0);
      chk("reset_pending_vec", 64'(pending_vec), 64'h0);
    end

    // Write r5, read on all ports same cycle and next
    nxt(); set_rd(5, 5, 5); set_wr(0, 5, 32'hDEADBEEF); #3;
    for (int i = 0; i < NRD; i++)
      chk("wr_same_cycle", 64'(rd_data[i*DW +: DW]), BYP ? 64'hDEADBEEF : 64'h0);
    nxt(); #3;
    for (int i = 0; i < NRD; i++)
      chk("wr_next_cycle", 64'(rd_data[i*DW +: DW]), 64'hDEADBEEF);

    // Write conflict on r7
    nxt(); set_wr(0, 7, 32'h11111111); set_wr(1, 7, 32'h22222222); set_rd(7, 7, 7); #3;
    nxt(); #3;
    chk("wr_conflict", 64'(rd_data[DW-1:0]), 64'h22222222);

    // Reservation and clear on r3
    nxt(); rsv_en = 1'b1; rsv_sel = 3; set_rd(3, 5, 0); #3;
    chk("rsv_same_cycle", 64'(rd_pending[0]), 64'd0);
    nxt(); #3;
    chk("rsv_vec", 64'(pending_vec), 64'h0008);
    chk("rsv_rd_pending", 64'(rd_pending), 64'b001);
    nxt(); rsv_en = 1'b1; rsv_sel = 3; #3;
    nxt(); #3;
    chk("double_rsv", 64'(pending_vec[3]), 64'd1);
    nxt(); nxt();
    nxt(); set_wr(1, 3, 32'h33333333); #3;
    chk("clear_same_cycle", 64'(rd_pending[0]), BYP ? 64'd0 : 64'd1);
    nxt(); #3;
    chk("clear_vec", 64'(pending_vec), 64'h0);
    chk("clear_data", 64'(rd_data[DW-1:0]), 64'h33333333);
    nxt(); set_wr(0, 3, 32'h44444444); rsv_en = 1'b1; rsv_sel = 3; #3;
    chk("rsv_wr_pend_T", 64'(rd_pending[0]), BYP ? 64'd1 : 64'd0);
    chk("rsv_wr_data_T", 64'(rd_data[DW-1:0]), BYP ? 64'h44444444 : 64'h33333333);
    nxt(); #3;
    chk("rsv_wr_vec", 64'(pending_vec), 64'h0008);
    chk("rsv_wr_data", 64'(rd_data[DW-1:0]), 64'h44444444);

    // Zero register ignores writes and reservations
    nxt(); set_wr(1, 0, 32'hFFFFFFFF); rsv_en = 1'b1; rsv_sel = 0; set_rd(0, 0, 3); #3;
    chk("zero_data_T", 64'(rd_data[DW-1:0]), 64'h0);
    chk("zero_pend_T", 64'(rd_pending[0]), 64'd0);
    nxt(); #3;
    chk("zero_data", 64'(rd_data[DW-1:0]), 64'h0);
    chk("zero_vec", 64'(pending_vec), 64'h0008);

    // Reset beats a same-cycle reserve and write
    nxt(); rsv_en = 1'b1; rsv_sel = 9; set_wr(0, 9, 32'hA5A5A5A5); rst = 1'b1;
    set_rd(9, 3, 7); #3;
    chk("rst_data_T", 64'(rd_data[DW-1:0]), 64'h0);
    nxt(); #3;
    chk("rst_r9", 64'(rd_data[DW-1:0]), 64'h0);
    chk("rst_r7", 64'(rd_data[2*DW +: DW]), 64'h0);
    chk("rst_vec", 64'(pending_vec), 64'h0);

    // Random traffic, biased toward low registers for collisions
    repeat (3000) begin
      nxt();
      rst = ($urandom_range(0, 63) == 0);
      wr_en = NWR'($urandom);
      for (int q = 0; q < NWR; q++) begin
        wr_sel[q*SW +: SW]  = $urandom_range(0, 1) ? SW'($urandom_range(0, 3)) : SW'($urandom);
        wr_data[q*DW +: DW] = $urandom;
      end
      for (int i = 0; i < NRD; i++)
        rd_sel[i*SW +: SW] = $urandom_range(0, 1) ? SW'($urandom_range(0, 3)) : SW'($urandom);
      rsv_en  = ($urandom_range(0, 2) == 0);
      rsv_sel = $urandom_range(0, 1) ? SW'($urandom_range(0, 3)) : SW'($urandom);
    end
    nxt(); #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised successor to the single-write-port CPU register file. Adds N read ports, M write ports, a per-register pending-write scoreboard for pipeline hazard detection, and a hardwired zero register. Sits between decode/issue (reads, reservations) and writeback (writes) in the Frost32 pipeline.

Parameters:
NUM_REGS, 16, number of architectural registers (power of 2, ≥4); SEL_W = clog2(NUM_REGS)
DATA_WIDTH, 32, register width in bits
NUM_RD_PORTS, 3, number of combinational read ports
NUM_WR_PORTS, 2, number of write ports; higher index = higher priority
ZERO_REG, 1, 1: register 0 reads 0, ignores writes and reservations; 0: register 0 is ordinary

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
rd_sel  in  NUM_RD_PORTS*SEL_W  read select per port
rd_data  out  NUM_RD_PORTS*DATA_WIDTH  read data per port
rd_pending  out  NUM_RD_PORTS  1 = selected register has an outstanding reservation
wr_en  in  NUM_WR_PORTS  write enable per port
wr_sel  in  NUM_WR_PORTS*SEL_W  write target per port
wr_data  in  NUM_WR_PORTS*DATA_WIDTH  write data per port
rsv_en  in  1  reserve (mark pending) register rsv_sel
rsv_sel  in  SEL_W  register to reserve
pending_vec  out  NUM_REGS  full scoreboard, bit i = register i pending

Behaviour:
- Reset (rst=1 at clk edge): all registers := 0, all pending bits := 0. rst overrides every write and reservation in the same cycle. Reset mid-operation discards in-flight reservations.
- Outputs after reset: rd_data = 0 on every port, rd_pending = 0, pending_vec = 0.
- Reads: combinational from current storage, 0-cycle latency. Without bypass, a write in cycle T is visible on rd_data in cycle T+1.
- Writes: on clk edge, for each port p with wr_en[p]=1, reg[wr_sel[p]] := wr_data[p].
- Same-register write conflict: the highest-index enabled port wins. Lower ports are dropped with no error.
- Scoreboard clear: any enabled write to register r clears pending[r] at the edge.
- Scoreboard set: rsv_en=1 sets pending[rsv_sel] at the edge.
- Reserve and write to the same register in the same cycle: the reservation wins, so pending stays 1 (new producer issued). Data is still written.
- Reserving an already-pending register: the bit stays 1. There is no count. Issue must not double-reserve, and the bench checks that the bit stays 1.
- rd_pending[i] = pending[rd_sel[i]], combinational.
- ZERO_REG=1:
  - rd_data for sel 0 is always 0 and rd_pending for sel 0 is always 0.
  - Writes and reservations to register 0 are ignored, including under bypass.
- Reads to the same register from several ports are independent and legal.

Optional Feature:
Macro REG_FILE_WR_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data combinationally when wr_en[p]=1 and wr_sel[p]==rd_sel[i]. The highest-index matching port is used.
  - rd_pending for that port is reported as 0 that cycle unless a same-cycle reservation targets the same register.
  - Forwarding is suppressed for register 0 when ZERO_REG=1 and while rst=1.
- Undefined: no forwarding; reads see storage only, with 1-cycle write-to-read latency as above.

Test Plan:
1. Reset then read all ports over sel 0..15 -> rd_data=0, pending_vec=16'h0000.
2. Write 0xDEADBEEF to r5 via port 0 at T, read r5 on ports 0..2 -> T: old value 0 (bypass off) or 0xDEADBEEF (bypass on); T+1: 0xDEADBEEF on all ports.
3. Both ports write r7 same cycle (p0=0x11111111, p1=0x22222222) -> r7=0x22222222 next cycle.
4. Reserve r3 at T -> pending_vec[3]=1 and rd_pending=1 for rd_sel=3 from T+1. Write r3 at T+4 -> pending clear at T+5. Repeat with reserve and write of r3 in the same cycle -> pending stays 1, r3 updated.
5. ZERO_REG=1: write 0xFFFFFFFF to r0 and reserve r0 -> rd_data=0, pending_vec[0]=0 every cycle.
6. Reserve r9, write r9=0xA5A5A5A5, assert rst in the same cycle -> next cycle r9=0 and pending_vec=0.
